// File: rtl/vend_credit_ctrl.sv
// vend_credit_ctrl: coin credit FSM driving an external add/subtract unit; define VEND_AUTO_CHANGE_EN to return leftover credit after a vend
module vend_credit_ctrl #(
    parameter logic [3:0] ITEM_PRICE = 4'd6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       coin_valid,
    input  logic [3:0] coin_value,
    output logic       coin_ready,
    input  logic       vend_req,
    input  logic       refund_req,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [1:0] alu_op,
    input  logic [4:0] alu_result,
    output logic [3:0] credit,
    output logic       busy,
    output logic       vend,
    output logic       vend_denied,
    output logic       coin_reject,
    output logic       change_valid,
    output logic [3:0] change_value
);
    typedef enum logic [2:0] {IDLE, ADD, SUB, DISPENSE, REFUND} state_t;
    state_t state, state_nx;
    logic [3:0] coin_q;
    logic refund_go, vend_go, coin_go;
    assign refund_go = refund_req && credit != 4'd0;
    assign vend_go = !refund_req && vend_req;
    assign coin_go = !refund_req && !vend_req && coin_valid;
    assign busy = state != IDLE;
    assign coin_ready = state == IDLE;
    // state, credit, latched coin and the registered overflow/borrow pulses
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            credit <= 4'd0;
            coin_q <= 4'd0;
            coin_reject <= 1'b0;
            vend_denied <= 1'b0;
        end else begin
            state <= state_nx;
            coin_reject <= state == ADD && alu_result[4];
            vend_denied <= state == SUB && alu_result[4];
            if (state == IDLE && coin_go) coin_q <= coin_value;
            if ((state == ADD || state == SUB) && !alu_result[4]) credit <= alu_result[3:0];
            else if (state == REFUND) credit <= 4'd0;
        end
    // next state and per-state outputs; ALU idles with op 11 outside ADD/SUB
    always_comb begin
        state_nx = IDLE;
        alu_a = 4'd0;
        alu_b = 4'd0;
        alu_op = 2'b11;
        vend = 1'b0;
        change_valid = 1'b0;
        change_value = 4'd0;
        case (state)
            IDLE: state_nx = refund_go ? REFUND : vend_go ? SUB : coin_go ? ADD : IDLE;
            ADD: begin
                alu_a = credit;
                alu_b = coin_q;
                alu_op = 2'b00;
            end
            SUB: begin
                alu_a = credit;
                alu_b = ITEM_PRICE;
                alu_op = 2'b01;
                state_nx = alu_result[4] ? IDLE : DISPENSE;
            end
            DISPENSE: begin
                vend = 1'b1;
`ifdef VEND_AUTO_CHANGE_EN
                state_nx = credit != 4'd0 ? REFUND : IDLE;
`else
                state_nx = IDLE;
`endif
            end
            REFUND: begin
                change_valid = 1'b1;
                change_value = credit;
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_vend_credit_ctrl.sv
// tb_vend_credit_ctrl: timeline model of the credit controller checked every cycle plus literal checkpoints
module tb_vend_credit_ctrl;
    localparam logic [3:0] PRICE = 4'd6;
`ifdef VEND_AUTO_CHANGE_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif
    logic clk = 1'b0, rst_n = 1'b0;
    logic coin_valid = 1'b0, vend_req = 1'b0, refund_req = 1'b0;
    logic [3:0] coin_value = 4'd0;
    logic coin_ready, busy, vend, vend_denied, coin_reject, change_valid;
    logic [3:0] alu_a, alu_b, credit, change_value;
    logic [1:0] alu_op;
    logic [4:0] alu_result;
    int checks = 0, passes = 0;
    int n_vend = 0, n_denied = 0, n_reject = 0, n_change = 0;
    logic [3:0] last_change = 4'd0;

    vend_credit_ctrl #(.ITEM_PRICE(PRICE)) dut (
        .clk(clk), .rst_n(rst_n), .coin_valid(coin_valid), .coin_value(coin_value),
        .coin_ready(coin_ready), .vend_req(vend_req), .refund_req(refund_req),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
        .credit(credit), .busy(busy), .vend(vend), .vend_denied(vend_denied),
        .coin_reject(coin_reject), .change_valid(change_valid), .change_value(change_value)
    );

    always #5 clk = ~clk;

    assign alu_result = alu_op == 2'b00 ? {1'b0, alu_a} + {1'b0, alu_b} :
                        alu_op == 2'b01 ? {1'b0, alu_a} - {1'b0, alu_b} : 5'd0;

    typedef struct packed {
        logic busy, coin_ready;
        logic [3:0] alu_a, alu_b;
        logic [1:0] alu_op;
        logic vend, vend_denied, coin_reject, change_valid;
        logic [3:0] change_value, credit;
    } out_t;
    typedef struct packed {
        logic idle;
        out_t o;
    } rec_t;

    rec_t sched[$];
    rec_t cur;
    logic [3:0] m_credit;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s got %0h want %0h", name, act, exp);
    endtask

    function automatic rec_t idle_rec(input logic [3:0] c);
        rec_t r;
        r = '0;
        r.idle = 1'b1;
        r.o.coin_ready = 1'b1;
        r.o.alu_op = 2'b11;
        r.o.credit = c;
        return r;
    endfunction

    function automatic rec_t busy_rec(input logic [3:0] c);
        rec_t r;
        r = '0;
        r.o.busy = 1'b1;
        r.o.alu_op = 2'b11;
        r.o.credit = c;
        return r;
    endfunction

    // schedules every cycle that one accepted request produces; returns the settled credit
    task automatic decide(input logic rf, input logic vr, input logic cv, input logic [3:0] cval,
                          input logic [3:0] c, output logic [3:0] nc);
        rec_t r;
        int s;
        nc = c;
        if (rf) begin
            if (c != 4'd0) begin
                r = busy_rec(c);
                r.o.change_valid = 1'b1;
                r.o.change_value = c;
                sched.push_back(r);
                nc = 4'd0;
            end
        end else if (vr) begin
            r = busy_rec(c);
            r.o.alu_a = c;
            r.o.alu_b = PRICE;
            r.o.alu_op = 2'b01;
            sched.push_back(r);
            if (c >= PRICE) begin
                s = c - PRICE;
                r = busy_rec(s[3:0]);
                r.o.vend = 1'b1;
                sched.push_back(r);
                nc = s[3:0];
                if (AUTO && s != 0) begin
                    r = busy_rec(s[3:0]);
                    r.o.change_valid = 1'b1;
                    r.o.change_value = s[3:0];
                    sched.push_back(r);
                    nc = 4'd0;
                end
            end else begin
                r = idle_rec(c);
                r.o.vend_denied = 1'b1;
                sched.push_back(r);
            end
        end else if (cv) begin
            r = busy_rec(c);
            r.o.alu_a = c;
            r.o.alu_b = cval;
            r.o.alu_op = 2'b00;
            sched.push_back(r);
            s = c + cval;
            if (s > 15) begin
                r = idle_rec(c);
                r.o.coin_reject = 1'b1;
                sched.push_back(r);
            end else nc = s[3:0];
        end
    endtask

    // model: decisions only at edges that end an idle cycle
    initial forever begin
        logic [3:0] nc;
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            sched.delete();
            m_credit = 4'd0;
            cur = idle_rec(4'd0);
        end else begin
            if (cur.idle) begin
                decide(refund_req, vend_req, coin_valid, coin_value, m_credit, nc);
                m_credit = nc;
            end
            cur = sched.size() != 0 ? sched.pop_front() : idle_rec(m_credit);
        end
    end

    // per-cycle compare and pulse bookkeeping
    initial forever begin
        out_t d;
        @(negedge clk);
        if (rst_n) begin
            d = {busy, coin_ready, alu_a, alu_b, alu_op, vend, vend_denied, coin_reject,
                 change_valid, change_value, credit};
            chk($sformatf("cycle@%0t", $time), 32'(d), 32'(cur.o));
            if (vend) n_vend++;
            if (vend_denied) n_denied++;
            if (coin_reject) n_reject++;
            if (change_valid) begin
                n_change++;
                last_change = change_value;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic coin(input logic [3:0] v);
        @(negedge clk);
        coin_valid = 1'b1;
        coin_value = v;
        @(negedge clk);
        coin_valid = 1'b0;
        idle(4);
    endtask

    task automatic vreq();
        @(negedge clk);
        vend_req = 1'b1;
        @(negedge clk);
        vend_req = 1'b0;
        idle(5);
    endtask

    task automatic rreq();
        @(negedge clk);
        refund_req = 1'b1;
        @(negedge clk);
        refund_req = 1'b0;
        idle(4);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_credit", 32'(credit), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_ready", 32'(coin_ready), 1);
        chk("reset_aluop", 32'(alu_op), 3);
        chk("reset_pulses", 32'({vend, vend_denied, coin_reject, change_valid, change_value}), 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        coin(4'd5);
        chk("credit_5", 32'(credit), 5);
        coin(4'd4);
        chk("credit_9", 32'(credit), 9);
        chk("no_reject", 32'(n_reject), 0);
        coin(4'd8);
        chk("reject_once", 32'(n_reject), 1);
        chk("credit_kept_9", 32'(credit), 9);
        vreq();
        chk("vend_once", 32'(n_vend), 1);
        chk("credit_after_vend", 32'(credit), AUTO ? 0 : 3);
        chk("auto_change_cnt", 32'(n_change), AUTO ? 1 : 0);
        if (AUTO) chk("auto_change_val", 32'(last_change), 3);
        coin(AUTO ? 4'd4 : 4'd1);
        chk("credit_4", 32'(credit), 4);
        vreq();
        chk("denied_once", 32'(n_denied), 1);
        chk("no_extra_vend", 32'(n_vend), 1);
        chk("credit_still_4", 32'(credit), 4);
        @(negedge clk);
        refund_req = 1'b1;
        coin_valid = 1'b1;
        coin_value = 4'd2;
        @(negedge clk);
        refund_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        coin_valid = 1'b0;
        idle(4);
        chk("refund_val_4", 32'(last_change), 4);
        chk("held_coin_credit", 32'(credit), 2);
        rreq();
        chk("refund_val_2", 32'(last_change), 2);
        chk("credit_zero", 32'(credit), 0);
        rreq();
        chk("no_refund_at_zero", 32'(n_change), AUTO ? 3 : 2);
        coin(4'd6);
        vreq();
        chk("exact_price_vend", 32'(n_vend), 2);
        chk("exact_price_credit", 32'(credit), 0);
        chk("exact_no_change", 32'(n_change), AUTO ? 3 : 2);
        coin(4'd0);
        coin(4'd15);
        chk("credit_15", 32'(credit), 15);
        coin(4'd1);
        chk("reject_twice", 32'(n_reject), 2);
        chk("credit_kept_15", 32'(credit), 15);
        @(negedge clk);
        coin_valid = 1'b1;
        coin_value = 4'd0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        coin_valid = 1'b0;
        #1;
        chk("async_credit", 32'(credit), 0);
        chk("async_busy", 32'(busy), 0);
        chk("async_aluop", 32'(alu_op), 3);
        chk("async_ready", 32'(coin_ready), 1);
        chk("async_pulses", 32'({vend, vend_denied, coin_reject, change_valid}), 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("resume_idle", 32'(busy), 0);
        coin(4'd3);
        chk("credit_3", 32'(credit), 3);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
